// File: rtl/pc_exec_control_pkg.sv
// Shared encodings for the execution sequencer.
// State codes are also decoded by the debug unit.
package pc_exec_control_pkg;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_RUN     = 3'd1;
  localparam logic [2:0] CMD_STEP    = 3'd2;
  localparam logic [2:0] CMD_PAUSE   = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLEAR = 3'd5
  } state_t;

endpackage

// File: rtl/pc_exec_control_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pc_exec_control.sv
// Execution sequencer: debug run/step/pause/restart,
// hazard stall merge, HALT drain and cycle counting.
import pc_exec_control_pkg::*;

module pc_exec_control #(
  parameter int len_cycles   = 32,
  parameter int drain_cycles = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [2:0]            cmd_code,
  output logic                  cmd_ready,
  input  logic                  hazard_stall,
  input  logic                  halt_detected,
  output logic                  pc_write,
  output logic                  pipe_enable,
  output logic                  pc_clear,
  output logic [len_cycles-1:0] cycle_count,
  output logic [2:0]            state,
  output logic                  done
);

  localparam int DW = $clog2(drain_cycles + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(drain_cycles);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] drain_q;
  logic [DW-1:0] drain_d;
  logic          done_q;
  logic          accept;

  assign cmd_ready = (state_q == ST_IDLE) |
                     (state_q == ST_RUN) |
                     (state_q == ST_DONE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_code)
            CMD_RUN:     state_d = ST_RUN;
            CMD_STEP:    state_d = ST_STEP;
            CMD_RESTART: state_d = ST_CLEAR;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        // HALT wins over any command accepted in the same cycle
        if (halt_detected) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (accept) begin
          case (cmd_code)
            CMD_PAUSE:   state_d = ST_IDLE;
            CMD_RESTART: state_d = ST_CLEAR;
            default:     state_d = ST_RUN;
          endcase
        end
      end
      ST_STEP: begin
        if (halt_detected) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRAIN_ONE;
        if (drain_q == DRAIN_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept && (cmd_code == CMD_RESTART)) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign pipe_enable = (state_q == ST_RUN) |
                       (state_q == ST_STEP) |
                       (state_q == ST_DRAIN);
  assign pc_write    = ((state_q == ST_RUN) | (state_q == ST_STEP)) &
                       ~hazard_stall & ~halt_detected;
  assign pc_clear    = (state_q == ST_CLEAR);
  assign state       = state_q;
  assign done        = done_q;

  sat_counter #(
    .WIDTH(len_cycles)
  ) u_cycles (
    .clk  (clk),
    .reset(reset),
    .en   (pipe_enable),
    .clr  (pc_clear),
    .count(cycle_count)
  );

endmodule

// File: tb/tb_pc_exec_control.sv
// Directed vector bench for pc_exec_control.
// A second instance with a 3-bit counter exercises saturation.
module tb_pc_exec_control;
  import pc_exec_control_pkg::*;

  typedef struct {
    logic        v;
    logic [2:0]  c;
    logic        st;
    logic        h;
    logic [7:0]  exp;
    logic        ck;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic        hazard_stall;
  logic        halt_detected;
  logic        cmd_ready, pc_write, pipe_enable, pc_clear, done;
  logic [31:0] cycle_count;
  logic [2:0]  state;
  logic        cmd_ready2, pc_write2, pipe_enable2, pc_clear2, done2;
  logic [2:0]  cycle_count2;
  logic [2:0]  state2;

  int checks = 0;
  int errors = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  pc_exec_control dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready),
    .hazard_stall(hazard_stall),
    .halt_detected(halt_detected),
    .pc_write(pc_write), .pipe_enable(pipe_enable),
    .pc_clear(pc_clear), .cycle_count(cycle_count),
    .state(state), .done(done)
  );

  pc_exec_control #(.len_cycles(3)) dut2 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready2),
    .hazard_stall(hazard_stall),
    .halt_detected(halt_detected),
    .pc_write(pc_write2), .pipe_enable(pipe_enable2),
    .pc_clear(pc_clear2), .cycle_count(cycle_count2),
    .state(state2), .done(done2)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic v, logic [2:0] c, logic st, logic h,
    logic [2:0] es, logic pw, logic pe, logic rd,
    logic dn, logic cl, logic ck = 1'b0,
    logic [31:0] cnt = 0);
    vec_t r;
    r.v   = v;
    r.c   = c;
    r.st  = st;
    r.h   = h;
    r.exp = {es, pw, pe, rd, dn, cl};
    r.ck  = ck;
    r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [7:0] outs();
    return {state, pc_write, pipe_enable,
            cmd_ready, done, pc_clear};
  endfunction

  task automatic drive(logic v, logic [2:0] c,
                       logic st, logic h);
    cmd_valid     = v;
    cmd_code      = c;
    hazard_stall  = st;
    halt_detected = h;
  endtask

  initial begin
    // run, halt on 10th run cycle, drain, done
    tv.push_back(mk(1, CMD_RUN, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 9; i++)
      tv.push_back(mk(i == 4, CMD_STEP, 0, 0,
                      1, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 1, 1, 0, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0, CMD_NOP, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, CMD_RUN, 0, 0, 4, 0, 0, 1, 1, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 4, 0, 0, 1, 0, 0,
                    1, 14));
    // restart from done
    tv.push_back(mk(1, CMD_RESTART, 0, 0, 4, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 5, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 0));
    // run with 2-cycle stall, then pause
    tv.push_back(mk(1, CMD_RUN, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 1, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 1, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 1, 0, 1, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 1, 0, 1, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 1, 1, 1, 1, 0, 0));
    tv.push_back(mk(1, CMD_PAUSE, 0, 0, 1, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 6));
    tv.push_back(mk(1, 3'd7, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 6));
    // restart, STEP held through clear, three steps
    tv.push_back(mk(1, CMD_RESTART, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, CMD_STEP, 0, 0, 5, 0, 0, 0, 0, 1));
    tv.push_back(mk(1, CMD_STEP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 0));
    tv.push_back(mk(1, CMD_STEP, 0, 0, 2, 1, 1, 0, 0, 0));
    tv.push_back(mk(1, CMD_STEP, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, CMD_STEP, 0, 0, 2, 1, 1, 0, 0, 0));
    tv.push_back(mk(1, CMD_STEP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 2));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 2, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 3));
    // stalled step still consumes its cycle
    tv.push_back(mk(1, CMD_STEP, 1, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 1, 0, 2, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 4));
    // halt during a step drains
    tv.push_back(mk(1, CMD_STEP, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 1, 2, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0, CMD_NOP, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, CMD_PAUSE, 0, 0, 4, 0, 0, 1, 1, 0,
                    1, 9));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 4, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, CMD_RESTART, 0, 0, 4, 0, 0, 1, 0, 0));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 5, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 0, 0,
                    1, 0));

    // reset held with RUN presented
    reset = 1'b0;
    drive(1, CMD_RUN, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pcw", 32'(pc_write), 0);
    chk("rst_pipe", 32'(pipe_enable), 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_done_clr", 32'({done, pc_clear}), 0);
    reset = 1'b1;
    drive(0, CMD_NOP, 0, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].c, tv[i].st, tv[i].h);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs()),
          32'(tv[i].exp));
      if (tv[i].ck) begin
        chk($sformatf("vec%0d_cnt", i), cycle_count,
            tv[i].cnt);
        chk($sformatf("vec%0d_cnt_sat3", i),
            32'(cycle_count2),
            (tv[i].cnt > 7) ? 32'd7 : tv[i].cnt);
      end
    end

    // pause and halt together, then reset inside drain
    @(negedge clk);
    drive(1, CMD_RUN, 0, 0);
    #1 chk("h6_idle", 32'(state), 0);
    @(negedge clk);
    drive(0, CMD_NOP, 0, 0);
    #1 chk("h6_run", 32'(state), 1);
    @(negedge clk);
    drive(1, CMD_PAUSE, 0, 1);
    #1 chk("h6_pair_pcw", 32'({state, pc_write}),
           32'({3'd1, 1'b0}));
    @(negedge clk);
    drive(0, CMD_NOP, 0, 0);
    #1 chk("h6_drain1", 32'({state, pipe_enable}),
           32'({3'd3, 1'b1}));
    @(negedge clk);
    #1 chk("h6_drain2_cnt", cycle_count, 3);
    #2 reset = 1'b0;
    #1;
    chk("h6_rst_outs", 32'(outs()),
        32'({3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    chk("h6_rst_cnt", cycle_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("h6_after", 32'({state, pipe_enable}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
